// File: rtl/snake_head_mover.sv
// Snake head mover: free-running move tick, one-cell head steps on each tick, and a sticky wall-crash flag.
// Optional build macro WRAP_AROUND_EN: the head wraps across grid edges instead of crashing into them.
module snake_head_mover #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int START_X  = 16,
  parameter int START_Y  = 12,
  parameter int MOVE_DIV = 5000000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [3:0]     direction,
  input  logic           enable,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic           moved,
  output logic           crashed
);

  localparam int CNT_W = $clog2(MOVE_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOVE_DIV - 1);
  localparam logic [X_W-1:0]   X_MAX   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(GRID_H - 1);

  localparam logic [3:0] DIR_DOWN  = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {IDLE, RUN, CRASHED} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [X_W-1:0]   x_next, x_inc, x_dec;
  logic [Y_W-1:0]   y_next, y_inc, y_dec;
  logic             moved_next, crashed_next;
  logic             legal, step, crash_hit;

  function automatic logic is_move(input logic [3:0] d);
    return (d == DIR_DOWN) || (d == DIR_UP) || (d == DIR_RIGHT) || (d == DIR_LEFT);
  endfunction

  assign legal = is_move(direction);
  assign step  = (state == RUN) && enable && (count == CNT_MAX);

  // Neighbour cells are range-checked here, so the adders never rely on overflow.
  assign x_inc = (head_x == X_MAX) ? '0    : head_x + X_W'(1);
  assign x_dec = (head_x == '0)    ? X_MAX : head_x - X_W'(1);
  assign y_inc = (head_y == Y_MAX) ? '0    : head_y + Y_W'(1);
  assign y_dec = (head_y == '0)    ? Y_MAX : head_y - Y_W'(1);

`ifdef WRAP_AROUND_EN
  assign crash_hit = 1'b0;
`else
  assign crash_hit = ((direction == DIR_DOWN)  && (head_y == Y_MAX)) ||
                     ((direction == DIR_UP)    && (head_y == '0))    ||
                     ((direction == DIR_RIGHT) && (head_x == X_MAX)) ||
                     ((direction == DIR_LEFT)  && (head_x == '0));
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      head_x  <= X_W'(START_X);
      head_y  <= Y_W'(START_Y);
      moved   <= 1'b0;
      crashed <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      head_x  <= x_next;
      head_y  <= y_next;
      moved   <= moved_next;
      crashed <= crashed_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable && legal) state_next = RUN;
      RUN:     if (step && legal && crash_hit) state_next = CRASHED;
      default: state_next = state;
    endcase
  end

  always_comb begin
    count_next   = count;
    x_next       = head_x;
    y_next       = head_y;
    moved_next   = 1'b0;
    crashed_next = crashed;
    case (state)
      RUN: begin
        if (enable) begin
          if (count == CNT_MAX) begin
            count_next = '0;
            if (legal) begin
              if (crash_hit) begin
                crashed_next = 1'b1;
              end else begin
                moved_next = 1'b1;
                case (direction)
                  DIR_DOWN:  y_next = y_inc;
                  DIR_UP:    y_next = y_dec;
                  DIR_RIGHT: x_next = x_inc;
                  default:   x_next = x_dec;
                endcase
              end
            end
          end else begin
            count_next = count + CNT_W'(1);
          end
        end
      end
      default: count_next = '0;
    endcase
  end

endmodule

// File: tb/tb_snake_head_mover.sv
// Directed bench for snake_head_mover on an 8x8 grid with a 4-cycle move tick.
module tb_snake_head_mover;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] direction;
  logic       enable;
  logic [2:0] head_x;
  logic [2:0] head_y;
  logic       moved;
  logic       crashed;

  int checks   = 0;
  int failures = 0;
  int pulses;

  snake_head_mover #(
    .GRID_W(8), .GRID_H(8), .X_W(3), .Y_W(3),
    .START_X(4), .START_Y(4), .MOVE_DIV(4)
  ) dut (
    .clock(clock), .reset(reset), .direction(direction), .enable(enable),
    .head_x(head_x), .head_y(head_y), .moved(moved), .crashed(crashed)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (moved === 1'b1) cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(head_x), 32'(x));
    chk({tag, "_y"}, 32'(head_y), 32'(y));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; direction = 4'b1111;
    tick(); tick();
    chk_head("reset", 4, 4);
    chk("reset_moved", 32'(moved), 0);
    chk("reset_crashed", 32'(crashed), 0);
    reset = 1'b0;

    // No move code: stays in IDLE
    enable = 1'b1;
    run(40, pulses);
    chk("idle_pulses", pulses, 0);
    chk_head("idle", 4, 4);
    chk("idle_crashed", 32'(crashed), 0);

    // Right three times, one step every fourth cycle after the IDLE->RUN edge
    direction = 4'b0100;
    tick();
    for (int k = 1; k <= 3; k++) begin
      run(3, pulses);
      chk("right_gap", pulses, 0);
      tick();
      chk("right_moved", 32'(moved), 1);
      chk_head("right", 4 + k, 4);
    end

    direction = 4'b0001;
    run(3, pulses);
    chk("down_gap", pulses, 0);
    tick();
    chk("down_moved", 32'(moved), 1);
    chk_head("down", 7, 5);

    direction = 4'b0010;
    run(3, pulses);
    tick();
    chk("up_moved", 32'(moved), 1);
    chk_head("up", 7, 4);

    direction = 4'b0100;
    run(3, pulses);
    tick();
`ifdef WRAP_AROUND_EN
    chk("wrap_r_moved", 32'(moved), 1);
    chk_head("wrap_r", 0, 4);
    chk("wrap_r_crashed", 32'(crashed), 0);
    direction = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      run(3, pulses);
      tick();
      chk("wrap_up_moved", 32'(moved), 1);
    end
    chk_head("wrap_u", 0, 7);
    chk("wrap_u_crashed", 32'(crashed), 0);
`else
    chk("crash_moved", 32'(moved), 0);
    chk("crash_flag", 32'(crashed), 1);
    chk_head("crash", 7, 4);
    direction = 4'b1000;
    run(12, pulses);
    chk("crashed_pulses", pulses, 0);
    chk_head("crashed_hold", 7, 4);
    chk("crashed_sticky", 32'(crashed), 1);
`endif

    // Asynchronous reset back to start
    reset = 1'b1;
    #1;
    chk_head("reset2", 4, 4);
    chk("reset2_crashed", 32'(crashed), 0);
    chk("reset2_moved", 32'(moved), 0);
    tick();
    reset = 1'b0;

    // Enable pause at count=2 holds the count
    enable = 1'b1; direction = 4'b0100;
    tick(); tick(); tick();
    enable = 1'b0;
    run(10, pulses);
    chk("pause_pulses", pulses, 0);
    chk_head("pause", 4, 4);
    enable = 1'b1;
    tick();
    chk("resume_early", 32'(moved), 0);
    tick();
    chk("resume_moved", 32'(moved), 1);
    chk_head("resume", 5, 4);

    // Non-one-hot code at step: held, still running
    direction = 4'b0011;
    run(4, pulses);
    chk("illegal_pulses", pulses, 0);
    chk_head("illegal", 5, 4);
    direction = 4'b0100;
    run(3, pulses);
    chk("after_illegal_gap", pulses, 0);
    tick();
    chk("after_illegal_moved", 32'(moved), 1);
    chk_head("after_illegal", 6, 4);

    // Reset mid-count discards the pending step
    tick(); tick();
    #3;
    reset = 1'b1;
    #1;
    chk_head("midreset", 4, 4);
    chk("midreset_moved", 32'(moved), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    run(3, pulses);
    chk("restart_gap", pulses, 0);
    tick();
    chk("restart_moved", 32'(moved), 1);
    chk_head("restart", 5, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
